// File: rtl/reaction_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reaction_session_ctrl
//  Description : Runs a multi-round reaction-timer session. Each round pulses
//                the timer start, records the result (time or fail), pulses
//                clear and waits a fixed gap. At session end a serial divider
//                produces the floor-average of successful times, alongside
//                the best time and the fail count.
//  Revision    : 1.0 - initial release
// ============================================================================
module reaction_session_ctrl #(
  parameter int ROUNDS       = 5,
  parameter int CLK_MS_COUNT = 100_000,
  parameter int GAP_MS       = 1_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        session_start,
  input  logic        session_abort,
  input  logic        tmr_result_valid,
  input  logic        tmr_fail,
  input  logic [13:0] tmr_time,
  output logic        tmr_start,
  output logic        tmr_clear,
  output logic        busy,
  output logic [3:0]  round_idx,
  output logic [3:0]  fail_count,
  output logic [13:0] best_time,
  output logic [13:0] avg_time,
  output logic        session_done
);

  localparam int TICK_W = (CLK_MS_COUNT > 1) ? $clog2(CLK_MS_COUNT) : 1;
  localparam int MS_W   = (GAP_MS > 1) ? $clog2(GAP_MS) : 1;

  localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(CLK_MS_COUNT - 1);
  localparam logic [MS_W-1:0]   c_MS_LAST   = MS_W'(GAP_MS - 1);
  localparam logic [3:0]        c_ROUNDS    = 4'(ROUNDS);
  localparam logic [4:0]        c_DIV_LAST  = 5'd18;
  localparam logic [13:0]       c_BEST_INIT = 14'h3FFF;

  localparam logic [2:0] c_ST_IDLE     = 3'd0;
  localparam logic [2:0] c_ST_ARM      = 3'd1;
  localparam logic [2:0] c_ST_WAIT_RES = 3'd2;
  localparam logic [2:0] c_ST_GAP      = 3'd3;
  localparam logic [2:0] c_ST_DIVIDE   = 3'd4;
  localparam logic [2:0] c_ST_DONE     = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [17:0]       sum_q;
  logic [3:0]        ok_cnt_q;
  logic [13:0]       best_int_q;
  logic [3:0]        round_q;
  logic [3:0]        fail_q;
  logic [13:0]       best_time_q;
  logic [13:0]       avg_q;
  logic [TICK_W-1:0] tick_q;
  logic [MS_W-1:0]   ms_q;
  logic [3:0]        rem_q;
  logic [17:0]       quot_q;
  logic [4:0]        div_cnt_q;

  logic              w_gap_end;
  logic              w_result;
  logic [4:0]        w_shift;
  logic [4:0]        w_diff;
  logic              w_ge;
  logic [3:0]        w_rem_nx;
  logic [17:0]       w_quot_nx;

  assign w_gap_end = (tick_q == c_TICK_LAST) && (ms_q == c_MS_LAST);
  assign w_result  = (state_q == c_ST_WAIT_RES) && tmr_result_valid;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    w_shift   = {rem_q, quot_q[17]};
    w_diff    = w_shift - {1'b0, ok_cnt_q};
    w_ge      = (w_shift >= {1'b0, ok_cnt_q});
    w_rem_nx  = 4'(w_ge ? w_diff : w_shift);
    w_quot_nx = {quot_q[16:0], w_ge};
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    if (session_abort) begin
      state_d = c_ST_IDLE;
    end else begin
      case (state_q)
        c_ST_IDLE, c_ST_DONE: if (session_start) state_d = c_ST_ARM;
        c_ST_ARM:             state_d = c_ST_WAIT_RES;
        c_ST_WAIT_RES:        if (tmr_result_valid) state_d = c_ST_GAP;
        c_ST_GAP: begin
          if (w_gap_end) begin
            state_d = (round_q == c_ROUNDS) ? c_ST_DIVIDE : c_ST_ARM;
          end
        end
        c_ST_DIVIDE: begin
          if ((ok_cnt_q == 4'd0) || (div_cnt_q == c_DIV_LAST)) state_d = c_ST_DONE;
        end
        default:              state_d = c_ST_IDLE;
      endcase
    end
  end

  // Outputs; timer strobes are gated by reset so nothing leaks out while it is held
  always_comb begin
    tmr_start    = reset_n && (state_q == c_ST_ARM) && !session_abort;
    tmr_clear    = reset_n && (session_abort || w_result);
    busy         = (state_q != c_ST_IDLE) && (state_q != c_ST_DONE);
    session_done = (state_q == c_ST_DONE);
    round_idx    = round_q;
    fail_count   = fail_q;
    best_time    = best_time_q;
    avg_time     = avg_q;
  end

  // Session datapath: result accumulation, gap timing and the serial divider
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q       <= '0;
      ok_cnt_q    <= '0;
      best_int_q  <= c_BEST_INIT;
      round_q     <= '0;
      fail_q      <= '0;
      best_time_q <= '0;
      avg_q       <= '0;
      tick_q      <= '0;
      ms_q        <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      div_cnt_q   <= '0;
    end else if (session_abort ||
                 (((state_q == c_ST_IDLE) || (state_q == c_ST_DONE)) && session_start)) begin
      // Abort and a fresh start both leave the datapath in its reset condition
      sum_q       <= '0;
      ok_cnt_q    <= '0;
      best_int_q  <= c_BEST_INIT;
      round_q     <= '0;
      fail_q      <= '0;
      best_time_q <= '0;
      avg_q       <= '0;
      tick_q      <= '0;
      ms_q        <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      div_cnt_q   <= '0;
    end else begin
      case (state_q)
        c_ST_WAIT_RES: begin
          if (tmr_result_valid) begin
            if (tmr_fail) begin
              fail_q <= fail_q + 4'd1;
            end else begin
              sum_q    <= sum_q + {4'd0, tmr_time};
              ok_cnt_q <= ok_cnt_q + 4'd1;
              if (tmr_time < best_int_q) best_int_q <= tmr_time;
            end
            round_q <= round_q + 4'd1;
            tick_q  <= '0;
            ms_q    <= '0;
          end
        end
        c_ST_GAP: begin
          if (tick_q == c_TICK_LAST) begin
            tick_q <= '0;
            ms_q   <= ms_q + MS_W'(1);
          end else begin
            tick_q <= tick_q + TICK_W'(1);
          end
          div_cnt_q <= '0;
        end
        c_ST_DIVIDE: begin
          if (ok_cnt_q == 4'd0) begin
            avg_q       <= '0;
            best_time_q <= '0;
          end else if (div_cnt_q == 5'd0) begin
            rem_q     <= '0;
            quot_q    <= sum_q;
            div_cnt_q <= 5'd1;
          end else begin
            rem_q     <= w_rem_nx;
            quot_q    <= w_quot_nx;
            div_cnt_q <= div_cnt_q + 5'd1;
            if (div_cnt_q == c_DIV_LAST) begin
              avg_q       <= w_quot_nx[13:0];
              best_time_q <= best_int_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reaction_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reaction_session_ctrl
//  Description : Self-checking bench for reaction_session_ctrl with directed
//                and randomized sessions checked against a simple result model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_session_ctrl;

  localparam int ROUNDS  = 3;
  localparam int CLK_MS  = 10;
  localparam int GAP_MS  = 2;
  localparam int GAP_CYC = CLK_MS * GAP_MS;
  localparam int DIV_LAT = 19;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        session_start, session_abort, tmr_result_valid, tmr_fail;
  logic [13:0] tmr_time;
  logic        tmr_start, tmr_clear, busy, session_done;
  logic [3:0]  round_idx, fail_count;
  logic [13:0] best_time, avg_time;

  always #5 clk = ~clk;

  reaction_session_ctrl #(
    .ROUNDS(ROUNDS), .CLK_MS_COUNT(CLK_MS), .GAP_MS(GAP_MS)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .session_start(session_start), .session_abort(session_abort),
    .tmr_result_valid(tmr_result_valid), .tmr_fail(tmr_fail), .tmr_time(tmr_time),
    .tmr_start(tmr_start), .tmr_clear(tmr_clear), .busy(busy),
    .round_idx(round_idx), .fail_count(fail_count),
    .best_time(best_time), .avg_time(avg_time), .session_done(session_done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int s_cyc    = 0;
  int n_start, n_clear, n_excl;
  logic obs_start, obs_clear, obs_done;

  int r_time [ROUNDS];
  bit r_fail [ROUNDS];

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Sample one cycle at negedge+1, then advance to the next negedge and drop pulses
  task automatic cyc_end();
    #1;
    obs_start = tmr_start;
    obs_clear = tmr_clear;
    obs_done  = session_done;
    if (tmr_start) n_start++;
    if (tmr_clear) n_clear++;
    if (tmr_start && tmr_clear) n_excl++;
    s_cyc = cyc;
    @(negedge clk);
    cyc++;
    session_start    = 1'b0;
    session_abort    = 1'b0;
    tmr_result_valid = 1'b0;
  endtask

  task automatic wait_start(input bit inject, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (inject && k == 5) session_start = 1'b1;
      cyc_end();
      if (obs_start) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_session(input bit inject);
    int  res_cyc, ok, sum, best, fails, exp_best, exp_avg, hold_best;
    bit  seen;
    n_start = 0; n_clear = 0; n_excl = 0; res_cyc = 0;
    session_start = 1'b1;
    cyc_end();
    check_val("busy_after_start", int'(busy), 1);
    check_val("cleared_round", int'(round_idx), 0);
    check_val("cleared_best", int'(best_time), 0);
    for (int r = 0; r < ROUNDS; r++) begin
      wait_start(inject, seen);
      check_val("start_seen", int'(seen), 1);
      if (r > 0) check_val("gap_len", s_cyc - res_cyc, GAP_CYC + 1);
      repeat ($urandom_range(0, 4)) begin
        if (inject && ($urandom_range(0, 1) == 1)) session_start = 1'b1;
        cyc_end();
      end
      tmr_result_valid = 1'b1;
      tmr_fail         = r_fail[r];
      tmr_time         = 14'(r_time[r]);
      if (inject) session_start = 1'b1;
      cyc_end();
      res_cyc = s_cyc;
      check_val("clear_on_result", int'(obs_clear), 1);
      check_val("round_idx", int'(round_idx), r + 1);
    end
    // Reference results from the round list
    ok = 0; sum = 0; best = 16383; fails = 0;
    for (int r = 0; r < ROUNDS; r++) begin
      if (r_fail[r]) fails++;
      else begin
        ok++;
        sum += r_time[r];
        if (r_time[r] < best) best = r_time[r];
      end
    end
    exp_best = (ok == 0) ? 0 : best;
    exp_avg  = (ok == 0) ? 0 : sum / ok;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (inject && k == 3) session_start = 1'b1;
      cyc_end();
      if (obs_done) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("done_seen", int'(seen), 1);
    check_val("done_latency", s_cyc - res_cyc, GAP_CYC + 1 + ((ok == 0) ? 1 : DIV_LAT));
    check_val("best_time", int'(best_time), exp_best);
    check_val("avg_time", int'(avg_time), exp_avg);
    check_val("fail_count", int'(fail_count), fails);
    check_val("round_final", int'(round_idx), ROUNDS);
    check_val("busy_done", int'(busy), 0);
    check_val("n_start", n_start, ROUNDS);
    check_val("n_clear", n_clear, ROUNDS);
    check_val("start_clear_overlap", n_excl, 0);
    hold_best = int'(best_time);
    repeat (5) cyc_end();
    check_val("done_hold", int'(session_done), 1);
    check_val("best_hold", int'(best_time), hold_best);
  endtask

  task automatic set_rounds(input int t0, input bit f0, input int t1, input bit f1,
                            input int t2, input bit f2);
    r_time[0] = t0; r_fail[0] = f0;
    r_time[1] = t1; r_fail[1] = f1;
    r_time[2] = t2; r_fail[2] = f2;
  endtask

  task automatic abort_test();
    bit seen;
    n_start = 0; n_clear = 0;
    session_start = 1'b1;
    cyc_end();
    wait_start(1'b0, seen);
    tmr_result_valid = 1'b1; tmr_fail = 1'b1; tmr_time = 14'd0;
    cyc_end();
    check_val("abort_r1_fail", int'(fail_count), 1);
    wait_start(1'b0, seen);
    check_val("abort_r2_start", int'(seen), 1);
    tmr_result_valid = 1'b1; tmr_fail = 1'b1; session_abort = 1'b1;
    cyc_end();
    check_val("abort_clear", int'(obs_clear), 1);
    check_val("abort_fail_count", int'(fail_count), 0);
    check_val("abort_round", int'(round_idx), 0);
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_done", int'(session_done), 0);
    n_start = 0;
    repeat (30) cyc_end();
    check_val("abort_no_start", n_start, 0);
  endtask

  task automatic reset_test();
    bit seen;
    session_start = 1'b1;
    cyc_end();
    wait_start(1'b0, seen);
    tmr_result_valid = 1'b1; tmr_fail = 1'b0; tmr_time = 14'd123;
    cyc_end();
    repeat (5) cyc_end();
    check_val("pre_reset_round", int'(round_idx), 1);
    reset_n = 1'b0;
    #1;
    check_val("rst_round_async", int'(round_idx), 0);
    check_val("rst_busy_async", int'(busy), 0);
    check_val("rst_clear_async", int'(tmr_clear), 0);
    cyc_end();
    reset_n = 1'b1;
    n_start = 0; n_clear = 0;
    repeat (40) cyc_end();
    check_val("rst_no_start", n_start, 0);
    check_val("rst_no_clear", n_clear, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    session_start = 1'b0; session_abort = 1'b0;
    tmr_result_valid = 1'b0; tmr_fail = 1'b0; tmr_time = 14'd0;
    repeat (3) @(negedge clk);
    #1;
    check_val("reset_round", int'(round_idx), 0);
    check_val("reset_best", int'(best_time), 0);
    check_val("reset_avg", int'(avg_time), 0);
    check_val("reset_busy", int'(busy), 0);
    check_val("reset_start", int'(tmr_start), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) cyc_end();

    set_rounds(250, 1'b0, 300, 1'b0, 200, 1'b0);
    run_session(1'b1);
    set_rounds(400, 1'b0, 0, 1'b1, 201, 1'b0);
    run_session(1'b0);
    set_rounds(0, 1'b1, 0, 1'b1, 0, 1'b1);
    run_session(1'b0);
    abort_test();
    reset_test();
    for (int s = 0; s < 6; s++) begin
      for (int r = 0; r < ROUNDS; r++) begin
        r_time[r] = (s == 0) ? 16383 : int'($urandom_range(1, 16383));
        r_fail[r] = ($urandom_range(0, 3) == 0);
      end
      run_session(bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reaction_session_ctrl.md
Name: reaction_session_ctrl

Overview:
- Sequences the reaction timer through a multi-round test session of ROUNDS trials.
- Each round: pulses the timer's start, waits for the round result, records it, pulses clear, then waits an inter-round gap.
- At session end, reports best time, floor-average of successful rounds and fail count for the sseg/bin2bcd display path.
- Sits between the push-button debouncers and the reaction timer.

Parameters:
- ROUNDS, 5, trials per session; legal range 1..15.
- CLK_MS_COUNT, 100_000, clock cycles per 1 ms tick (10 ns clock).
- GAP_MS, 1_000, idle gap between rounds, in ms.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- session_start  input  1  level/pulse; begins a session when idle or done
- session_abort  input  1  aborts the session from any state
- tmr_result_valid  input  1  1-cycle pulse from the timer when it enters done or fail
- tmr_fail  input  1  qualifies tmr_result_valid; 1 = timeout/fail
- tmr_time  input  14  reaction time in ms; sampled with tmr_result_valid
- tmr_start  output  1  1-cycle start pulse to the timer
- tmr_clear  output  1  1-cycle clear pulse to the timer
- busy  output  1  high in every state except IDLE and DONE
- round_idx  output  4  completed-round count, 0..ROUNDS
- fail_count  output  4  failed rounds in the session
- best_time  output  14  minimum successful time in ms; 0 if none
- avg_time  output  14  floor(sum/ok_count); 0 if none
- session_done  output  1  high while in DONE

Behaviour:
- Reset: state IDLE; all outputs 0; internal sum (18 bit), ok_count (4 bit), best register (14 bit, 14'h3FFF internally), tick/ms counters cleared.
- States: IDLE, ARM, WAIT_RES, GAP, DIVIDE, DONE.
- IDLE / DONE:
  - session_start=1 clears sum, ok_count, fail_count, round_idx, best_time, avg_time; sets internal best to 14'h3FFF; next state ARM.
  - session_start is ignored in every other state.
- ARM: tmr_start=1 for exactly one cycle, then WAIT_RES.
- WAIT_RES: waits indefinitely. On tmr_result_valid, in the same edge:
  - if tmr_fail: fail_count += 1.
  - else: sum += tmr_time (18-bit, no overflow for 15 × 16383); ok_count += 1; best = min(best, tmr_time).
  - round_idx += 1; tmr_clear=1 on this cycle; next state GAP with tick/ms counters zeroed.
- GAP:
  - tick counter wraps at CLK_MS_COUNT-1 and increments the ms counter.
  - When ms counter == GAP_MS-1 and tick == CLK_MS_COUNT-1: if round_idx == ROUNDS go to DIVIDE, else go to ARM.
  - Gap length is exactly GAP_MS*CLK_MS_COUNT cycles.
- DIVIDE:
  - If ok_count == 0: avg_time=0, best_time=0, then DONE after 1 cycle.
  - Else: restoring divider, sum / ok_count, one quotient bit per cycle. Takes 1 load cycle plus 18 iterations.
  - On completion: avg_time = quotient[13:0] (cannot exceed 14 bits); best_time = best; next state DONE.
  - Total DIVIDE latency: 19 cycles.
- DONE: session_done=1; results held stable until the next session_start or session_abort.
- session_abort has priority over every other event, including a coincident tmr_result_valid or session_start:
  - tmr_clear=1 for one cycle; all result outputs return to reset values; next state IDLE.
- tmr_result_valid outside WAIT_RES is ignored.
- tmr_start and tmr_clear are never asserted in the same cycle.
- Reset asserted mid-operation: immediate return to reset values; no tmr_start/tmr_clear glitch.

Test Plan:
(bench uses ROUNDS=3, CLK_MS_COUNT=10, GAP_MS=2)
- session_start; results 250, 300, 200 (no fail) -> exactly 3 tmr_start pulses; each gap 20 cycles; best_time=200, avg_time=250, fail_count=0, round_idx=3, session_done=1 at 19 cycles after the final gap.
- Results 400, fail, 201 -> fail_count=1, best_time=201, avg_time=300 (601/2 floored).
- All three rounds fail -> best_time=0, avg_time=0, fail_count=3, DONE 1 cycle after DIVIDE entry.
- session_abort coincident with tmr_result_valid in round 2 -> tmr_clear pulse; IDLE; all outputs 0; fail_count not incremented.
- session_start pulsed during WAIT_RES and GAP -> ignored; round count unaffected; session_start in DONE starts a new session with cleared results.
- reset_n low during GAP -> all outputs 0 asynchronously; after release, no tmr_start until session_start.
